inst_fetcher: RTL and testbench
===============================

Name: inst_fetcher

Overview:
- Front-end stage directly upstream of the decoder.
- Holds the PC and issues one-at-a-time fetch requests to the instruction cache.
- Applies static next-PC prediction: JAL is taken; B-type is taken when backward, not taken when forward.
- Buffers fetched instructions in a small FIFO that the decoder drains. A ROB flush redirects the PC and discards all in-flight work.

Parameters:
- IQ_SIZE_BIT, 2: log2 of instruction-queue depth (IQ_SIZE = 4 entries).
- RESET_PC, 32'h0: PC loaded on reset.

Ports:
- clk_in  input  1  system clock; all state updates on rising edge.
- rst_in  input  1  reset; synchronous, active-high.
- rdy_in  input  1  ready; when low, all state is frozen.
- clear_in  input  1  ROB flush/mispredict redirect.
- clear_pc  input  32  redirect target, valid with clear_in.
- icache_req  output  1  fetch request; held high until icache_valid.
- icache_addr  output  32  fetch address; stable while icache_req is high.
- icache_valid  input  1  response strobe, one cycle.
- icache_inst  input  32  fetched instruction, valid with icache_valid.
- dec_stall  input  1  decoder cannot accept this cycle (decoder is_stall).
- inst_valid  output  1  queue head is valid.
- inst_out  output  32  queue-head instruction.
- inst_addr_out  output  32  queue-head PC.
- inst_pred_taken  output  1  queue-head prediction (1 = predicted taken).

Behaviour:
- Reset (rst_in=1 at edge):
  - pc=RESET_PC, state=FETCH, queue empty (head=tail=count=0).
  - icache_req=0, inst_valid=0, inst_out/inst_addr_out=0, inst_pred_taken=0.
- rdy_in=0: no register changes. Memory never asserts icache_valid while rdy_in=0.
- Priority per cycle: rst_in > clear_in > normal operation.
- States:
  - FETCH:
    - if count < IQ_SIZE: drive icache_req=1, icache_addr=pc, go WAIT.
    - else stay, icache_req=0.
  - WAIT:
    - icache_req=1, icache_addr=pc held.
    - On icache_valid: push {icache_inst, pc, pred} at tail, pc <= next_pc, go FETCH.
  - DROP:
    - icache_req=1 held with the stale address until icache_valid; the response is discarded, then go FETCH.
    - pc already holds the redirect target.
- Back-to-back fetches: the response cycle moves the FSM to FETCH and the next request issues the following cycle. Throughput is one instruction per 2 + cache-latency cycles.
- next_pc and pred are computed combinationally from icache_inst and pc:
  - opcode 7'b1101111 (JAL): next_pc = pc + sext(J-imm), pred=1.
  - opcode 7'b1100011 (B-type): if B-imm sign bit is 1, next_pc = pc + sext(B-imm), pred=1; else pc+4, pred=0.
  - otherwise (including JALR): next_pc = pc+4, pred=0.
  - All address arithmetic is modulo 2^32.
- Queue:
  - Circular buffer of IQ_SIZE entries; head/tail are IQ_SIZE_BIT wide and wrap naturally; count is IQ_SIZE_BIT+1 bits.
  - inst_valid = (count != 0); outputs show head entry combinationally.
  - Pop when inst_valid && !dec_stall; head++.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - A push never overflows: a request is launched only with count < IQ_SIZE, at most one request is outstanding, and count cannot grow before the response.
- clear_in=1:
  - Queue emptied (head=tail=count=0); pc <= clear_pc; any pop that cycle is ignored.
  - If state=WAIT and icache_valid=0: go DROP.
  - If state=WAIT and icache_valid=1: discard the response, go FETCH.
  - If state=DROP: stay DROP (or go FETCH if icache_valid=1 that cycle).
  - If state=FETCH: go FETCH, no request this cycle.
- Reset mid-WAIT/DROP: state returns to FETCH. The memory controller is reset in the same cycle, so no stale response arrives.

Test Plan:
- Reset, RESET_PC=0, cache returns ADDI (32'h00100093) with 1-cycle latency → requests at 0,4,8; decoder sees inst_addr_out 0,4,8 with pred_taken=0; first inst_valid 3 cycles after reset release.
- JAL at pc=0x10 with imm=+0x20 (32'h020000EF) → entry pred_taken=1; next icache_addr=0x30.
- BEQ at pc=0x40 with imm=-8 (32'hFE000CE3) → pred_taken=1, next addr 0x38. BEQ with imm=+8 (32'h00000463) → pred_taken=0, next addr 0x44.
- dec_stall held high for 20 cycles → queue fills to 4, icache_req drops to 0. Release stall → four pops in four cycles, in order, then fetching resumes.
- clear_in with clear_pc=0x100 while in WAIT, response arrives 3 cycles later → response discarded, inst_valid=0, next request addr=0x100.
- clear_in in the same cycle as icache_valid, with a concurrent pop and 2 queued entries → queue empty next cycle, response dropped, next request to clear_pc.

Source files
------------

// File: rtl/inst_fetcher.sv
// inst_fetcher: holds the PC, issues one-at-a-time fetches to the icache,
// applies static next-PC prediction and buffers fetched instructions in a
// small circular queue drained by the decoder. A flush (clear_in) redirects
// the PC and throws away all in-flight work.
//
// state    | meaning
// ST_FETCH | no request outstanding; launches a fetch when the queue has room
// ST_WAIT  | request outstanding; its response is pushed into the queue
// ST_DROP  | request outstanding from before a flush; its response is discarded
module inst_fetcher #(
    parameter int          IQ_SIZE_BIT = 2,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic [31:0] clear_pc,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_valid,
    input  logic [31:0] icache_inst,
    input  logic        dec_stall,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_addr_out,
    output logic        inst_pred_taken
);

    localparam int                   IQ_SIZE   = 1 << IQ_SIZE_BIT;
    localparam logic [IQ_SIZE_BIT:0] IQ_FULL   = (IQ_SIZE_BIT + 1)'(IQ_SIZE);
    localparam logic [6:0]           OP_JAL    = 7'b1101111;
    localparam logic [6:0]           OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic        req_nxt;
    logic [31:0] addr_nxt;

    logic [31:0] j_imm;
    logic [31:0] b_imm;
    logic [31:0] pred_pc;
    logic        pred_taken;

    logic        push;
    logic        pop;
    logic        q_clear;

    logic [31:0]            iq_inst [IQ_SIZE];
    logic [31:0]            iq_pc   [IQ_SIZE];
    logic [IQ_SIZE-1:0]     iq_pred;
    logic [IQ_SIZE_BIT-1:0] head;
    logic [IQ_SIZE_BIT-1:0] tail;
    logic [IQ_SIZE_BIT:0]   count;

    // Static prediction on the returning word: JAL and backward branches taken.
    always_comb begin
        j_imm = {{12{icache_inst[31]}}, icache_inst[19:12], icache_inst[20],
                 icache_inst[30:21], 1'b0};
        b_imm = {{20{icache_inst[31]}}, icache_inst[7], icache_inst[30:25],
                 icache_inst[11:8], 1'b0};
        pred_pc    = pc + 32'd4;
        pred_taken = 1'b0;
        if (icache_inst[6:0] == OP_JAL) begin
            pred_pc    = pc + j_imm;
            pred_taken = 1'b1;
        end else if ((icache_inst[6:0] == OP_BRANCH) && icache_inst[31]) begin
            pred_pc    = pc + b_imm;
            pred_taken = 1'b1;
        end
    end

    // Next-state, request and queue-control decode; a flush overrides everything.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        req_nxt   = icache_req;
        addr_nxt  = icache_addr;
        push      = 1'b0;
        q_clear   = 1'b0;
        pop       = inst_valid && !dec_stall && !clear_in;

        if (clear_in) begin
            q_clear = 1'b1;
            pc_nxt  = clear_pc;
            case (state)
                ST_WAIT, ST_DROP: begin
                    // A response landing with the flush is simply dropped;
                    // otherwise keep the stale request up until it returns.
                    if (icache_valid) begin
                        state_nxt = ST_FETCH;
                        req_nxt   = 1'b0;
                    end else begin
                        state_nxt = ST_DROP;
                    end
                end
                default: begin
                    state_nxt = ST_FETCH;
                    req_nxt   = 1'b0;
                end
            endcase
        end else begin
            case (state)
                ST_FETCH: begin
                    // Room is checked against the current count; the single
                    // outstanding request guarantees the push cannot overflow.
                    if (count < IQ_FULL) begin
                        req_nxt   = 1'b1;
                        addr_nxt  = pc;
                        state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (icache_valid) begin
                        push      = 1'b1;
                        pc_nxt    = pred_pc;
                        req_nxt   = 1'b0;
                        state_nxt = ST_FETCH;
                    end
                end
                ST_DROP: begin
                    if (icache_valid) begin
                        req_nxt   = 1'b0;
                        state_nxt = ST_FETCH;
                    end
                end
                default: begin
                    req_nxt   = 1'b0;
                    state_nxt = ST_FETCH;
                end
            endcase
        end
    end

    // FSM state, PC and the registered icache request/address.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            icache_req  <= 1'b0;
            icache_addr <= '0;
        end else if (rdy_in) begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            icache_req  <= req_nxt;
            icache_addr <= addr_nxt;
        end
    end

    // Instruction queue: push at tail, pop at head, flush empties it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            iq_pred <= '0;
            for (int i = 0; i < IQ_SIZE; i++) begin
                iq_inst[i] <= '0;
                iq_pc[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (q_clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    iq_inst[tail] <= icache_inst;
                    iq_pc[tail]   <= pc;
                    iq_pred[tail] <= pred_taken;
                    tail          <= tail + IQ_SIZE_BIT'(1);
                end
                if (pop) begin
                    head <= head + IQ_SIZE_BIT'(1);
                end
                if (push && !pop) begin
                    count <= count + (IQ_SIZE_BIT + 1)'(1);
                end else if (pop && !push) begin
                    count <= count - (IQ_SIZE_BIT + 1)'(1);
                end
            end
        end
    end

    assign inst_valid      = (count != '0);
    assign inst_out        = iq_inst[head];
    assign inst_addr_out   = iq_pc[head];
    assign inst_pred_taken = iq_pred[head];

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher with a small behavioural icache model.
module tb_inst_fetcher;

    localparam logic [31:0] ADDI     = 32'h00100093;
    localparam logic [31:0] JAL_P20  = 32'h020000EF;
    localparam logic [31:0] BEQ_M8   = 32'hFE000CE3;
    localparam logic [31:0] BEQ_P8   = 32'h00000463;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        clear_in = 1'b0;
    logic [31:0] clear_pc = '0;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_valid = 1'b0;
    logic [31:0] icache_inst = '0;
    logic        dec_stall = 1'b0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_addr_out;
    logic        inst_pred_taken;

    int checks = 0;
    int errors = 0;
    int mem_lat = 1;
    int mem_cnt = 0;
    logic [31:0] prog [logic [31:0]];

    inst_fetcher dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .clear_in        (clear_in),
        .clear_pc        (clear_pc),
        .icache_req      (icache_req),
        .icache_addr     (icache_addr),
        .icache_valid    (icache_valid),
        .icache_inst     (icache_inst),
        .dec_stall       (dec_stall),
        .inst_valid      (inst_valid),
        .inst_out        (inst_out),
        .inst_addr_out   (inst_addr_out),
        .inst_pred_taken (inst_pred_taken)
    );

    initial forever #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (prog.exists(a)) return prog[a];
        return ADDI;
    endfunction

    // icache model: responds for one cycle once the request has been seen for mem_lat edges
    initial forever begin
        @(posedge clk_in);
        #1;
        if (rst_in) begin
            icache_valid = 1'b0;
            mem_cnt = 0;
        end else if (rdy_in) begin
            if (icache_valid) begin
                icache_valid = 1'b0;
                mem_cnt = 0;
            end else if (icache_req) begin
                mem_cnt++;
                if (mem_cnt > mem_lat) begin
                    icache_valid = 1'b1;
                    icache_inst = mem_word(icache_addr);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        clear_in = 1'b0;
        rdy_in = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_in);
        checks++; if (icache_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b expected 0", icache_req); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", inst_valid); end
        checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", inst_out); end
        checks++; if (inst_addr_out !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", inst_addr_out); end
        checks++; if (inst_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred: got %0b expected 0", inst_pred_taken); end
        rst_in = 1'b0;
        @(negedge clk_in);
        checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h0) begin errors++; $display("FAIL first_req: got req %0b addr %h expected 1 0", icache_req, icache_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL early_valid1: got %0b expected 0", inst_valid); end
        @(negedge clk_in);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL early_valid2: got %0b expected 0", inst_valid); end
        @(negedge clk_in);
        checks++; if (inst_valid !== 1'b1 || inst_addr_out !== 32'h0 || inst_out !== ADDI || inst_pred_taken !== 1'b0) begin
            errors++; $display("FAIL first_inst: got v%0b a%h i%h p%0b expected 1 0 %h 0", inst_valid, inst_addr_out, inst_out, inst_pred_taken, ADDI);
        end
    endtask

    task automatic test_prediction_flow();
        logic [31:0] exp_a [13];
        logic        exp_p [13];
        logic [31:0] exp_i;
        int got;
        exp_a = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h30, 32'h34,
                  32'h38, 32'h3C, 32'h40, 32'h38, 32'h3C, 32'h40};
        exp_p = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        dec_stall = 1'b0;
        do_reset();
        got = 0;
        for (int c = 0; c < 200 && got < 13; c++) begin
            @(negedge clk_in);
            if (inst_valid && !dec_stall) begin
                exp_i = (exp_a[got] == 32'h10) ? JAL_P20 : (exp_a[got] == 32'h40) ? BEQ_M8 : ADDI;
                checks++;
                if (inst_addr_out !== exp_a[got] || inst_pred_taken !== exp_p[got] || inst_out !== exp_i) begin
                    errors++;
                    $display("FAIL flow_entry%0d: got a%h p%0b i%h expected a%h p%0b i%h", got,
                             inst_addr_out, inst_pred_taken, inst_out, exp_a[got], exp_p[got], exp_i);
                end
                got++;
            end
        end
        checks++; if (got !== 13) begin errors++; $display("FAIL flow_count: got %0d entries expected 13", got); end
    endtask

    task automatic test_fwd_branch();
        int got;
        logic [31:0] exp_a [2];
        logic [31:0] exp_i [2];
        exp_a = '{32'h40, 32'h44};
        exp_i = '{BEQ_P8, ADDI};
        prog[32'h40] = BEQ_P8;
        @(negedge clk_in);
        clear_in = 1'b1;
        clear_pc = 32'h40;
        @(negedge clk_in);
        clear_in = 1'b0;
        got = 0;
        for (int c = 0; c < 60 && got < 2; c++) begin
            @(negedge clk_in);
            if (inst_valid && !dec_stall) begin
                checks++;
                if (inst_addr_out !== exp_a[got] || inst_pred_taken !== 1'b0 || inst_out !== exp_i[got]) begin
                    errors++;
                    $display("FAIL fwd_entry%0d: got a%h p%0b i%h expected a%h p0 i%h", got,
                             inst_addr_out, inst_pred_taken, inst_out, exp_a[got], exp_i[got]);
                end
                got++;
            end
        end
        checks++; if (got !== 2) begin errors++; $display("FAIL fwd_count: got %0d entries expected 2", got); end
    endtask

    task automatic test_stall();
        logic [31:0] exp_a [5];
        exp_a = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};
        dec_stall = 1'b1;
        do_reset();
        repeat (20) @(negedge clk_in);
        checks++; if (icache_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %0b expected 0", icache_req); end
        checks++; if (inst_valid !== 1'b1 || inst_addr_out !== 32'h0) begin errors++; $display("FAIL stall_head: got v%0b a%h expected 1 0", inst_valid, inst_addr_out); end
        dec_stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk_in);
            checks++;
            if (inst_valid !== 1'b1 || inst_addr_out !== exp_a[k]) begin
                errors++;
                $display("FAIL drain%0d: got v%0b a%h expected 1 %h", k, inst_valid, inst_addr_out, exp_a[k]);
            end
        end
        checks++; if (inst_pred_taken !== 1'b1 || inst_out !== JAL_P20) begin errors++; $display("FAIL resume_jal: got p%0b i%h expected 1 %h", inst_pred_taken, inst_out, JAL_P20); end
    endtask

    task automatic test_clear_wait();
        logic [31:0] stale;
        logic saw, leaked, done;
        dec_stall = 1'b0;
        mem_lat = 3;
        do_reset();
        @(negedge clk_in);
        checks++; if (icache_req !== 1'b1) begin errors++; $display("FAIL cw_req: got %0b expected 1", icache_req); end
        stale = icache_addr;
        clear_in = 1'b1;
        clear_pc = 32'h100;
        @(negedge clk_in);
        clear_in = 1'b0;
        checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h0) begin errors++; $display("FAIL cw_drop_hold: got req %0b addr %h expected 1 0", icache_req, icache_addr); end
        saw = 1'b0; leaked = 1'b0; done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk_in);
            if (inst_valid) leaked = 1'b1;
            if (saw && icache_req) begin
                checks++; if (icache_addr !== 32'h100) begin errors++; $display("FAIL cw_redirect: got %h expected 00000100", icache_addr); end
                done = 1'b1;
            end
            if (icache_valid) saw = 1'b1;
        end
        checks++; if (leaked !== 1'b0) begin errors++; $display("FAIL cw_discard: got inst_valid %0b expected 0 (stale %h)", leaked, stale); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL cw_timeout: got %0b expected 1", done); end
        mem_lat = 1;
    endtask

    task automatic test_clear_with_valid();
        int nresp;
        logic done;
        dec_stall = 1'b1;
        do_reset();
        nresp = 0; done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk_in);
            if (icache_valid) begin
                nresp++;
                if (nresp == 3) begin
                    checks++; if (inst_valid !== 1'b1 || inst_addr_out !== 32'h0) begin errors++; $display("FAIL cv_pre: got v%0b a%h expected 1 0", inst_valid, inst_addr_out); end
                    clear_in = 1'b1;
                    clear_pc = 32'h200;
                    dec_stall = 1'b0;
                    @(negedge clk_in);
                    clear_in = 1'b0;
                    checks++; if (inst_valid !== 1'b0 || icache_req !== 1'b0) begin errors++; $display("FAIL cv_empty: got v%0b req %0b expected 0 0", inst_valid, icache_req); end
                    @(negedge clk_in);
                    checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h200) begin errors++; $display("FAIL cv_redirect: got req %0b addr %h expected 1 00000200", icache_req, icache_addr); end
                    done = 1'b1;
                end
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL cv_timeout: got %0b expected 1", done); end
        done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk_in);
            if (inst_valid) begin
                checks++; if (inst_addr_out !== 32'h200) begin errors++; $display("FAIL cv_first: got %h expected 00000200", inst_addr_out); end
                done = 1'b1;
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL cv_first_timeout: got %0b expected 1", done); end
    endtask

    task automatic test_rdy_freeze();
        logic done;
        dec_stall = 1'b1;
        do_reset();
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk_in);
            if (inst_valid) done = 1'b1;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rdy_timeout: got %0b expected 1", done); end
        @(negedge clk_in);
        checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h4) begin errors++; $display("FAIL rdy_pre: got req %0b addr %h expected 1 00000004", icache_req, icache_addr); end
        rdy_in = 1'b0;
        dec_stall = 1'b0;
        clear_pc = 32'h300;
        repeat (5) @(negedge clk_in);
        checks++; if (icache_req !== 1'b1 || icache_addr !== 32'h4) begin errors++; $display("FAIL rdy_hold_req: got req %0b addr %h expected 1 00000004", icache_req, icache_addr); end
        checks++; if (inst_valid !== 1'b1 || inst_addr_out !== 32'h0) begin errors++; $display("FAIL rdy_hold_q: got v%0b a%h expected 1 0", inst_valid, inst_addr_out); end
        dec_stall = 1'b1;
        rdy_in = 1'b1;
        repeat (3) @(negedge clk_in);
        checks++; if (inst_valid !== 1'b1 || inst_addr_out !== 32'h0) begin errors++; $display("FAIL rdy_resume: got v%0b a%h expected 1 0", inst_valid, inst_addr_out); end
    endtask

    initial begin
        prog[32'h10] = JAL_P20;
        prog[32'h40] = BEQ_M8;
        test_reset();
        test_prediction_flow();
        test_fwd_branch();
        test_stall();
        test_clear_wait();
        test_clear_with_valid();
        test_rdy_freeze();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
